// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising Fibonacci LFSR checker.
// In SEARCH it loads received bits into its history until it has seen
// LOCK_COUNT consecutive correct predictions. Once LOCKED it free-runs on its
// own prediction, so a single flipped input bit costs exactly one counted
// error. Too many errors inside one observation window drop it back to SEARCH.
module prbs_checker #(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter int              LOCK_COUNT = 32,
  parameter int              WINDOW     = 64,
  parameter int              LOSS_ERRS  = 8,
  parameter int              ERR_W      = 16,
  parameter int              CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int MC_W   = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W   = $clog2(LOSS_ERRS + 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    hist;
  logic [FILL_W-1:0]   fill;
  logic [MC_W-1:0]     match_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [WE_W-1:0]     win_errs;

  logic pred;
  logic mismatch;
  logic search_match;
  logic win_end;
  logic enter_lock;
  logic lose_lock;

  // Prediction of the current bit from the previous WIDTH bits.
  assign pred     = ^(hist & TAPS);
  assign mismatch = (pred != in_bit);

  // A prediction is only trusted once the history is full and non-zero;
  // the all-zero state is a fixed point of the LFSR and must never lock.
  assign search_match = (fill == FILL_W'(WIDTH)) && (hist != '0) && !mismatch;

  assign win_end = (win_cnt == WIN_W'(WINDOW - 1));
  assign locked  = (state == ST_LOCKED);

  // Next-state logic: lock on the LOCK_COUNT-th consecutive match, drop lock
  // when the current bit brings the window error tally to LOSS_ERRS.
  always_comb begin
    state_d    = state;
    enter_lock = 1'b0;
    lose_lock  = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (in_valid && search_match && (match_cnt == MC_W'(LOCK_COUNT - 1))) begin
          state_d    = ST_LOCKED;
          enter_lock = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (in_valid && mismatch && (win_errs == WE_W'(LOSS_ERRS - 1))) begin
          state_d   = ST_SEARCH;
          lose_lock = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_SEARCH;
    else     state <= state_d;
  end

  // History, fill level and consecutive-match tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (in_valid) begin
      if (state == ST_SEARCH) begin
        hist <= {hist[WIDTH-2:0], in_bit};
        if (fill != FILL_W'(WIDTH)) fill <= fill + FILL_W'(1);
        if (search_match && !enter_lock) match_cnt <= match_cnt + MC_W'(1);
        else                             match_cnt <= '0;
      end else begin
        // Free-run on our own prediction so input errors do not propagate.
        hist <= {hist[WIDTH-2:0], pred};
        if (lose_lock) begin
          fill      <= '0;
          match_cnt <= '0;
        end
      end
    end
  end

  // Loss-of-lock observation window: bit position and error tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      win_errs <= '0;
    end else if (in_valid) begin
      if (enter_lock) begin
        win_cnt  <= '0;
        win_errs <= '0;
      end else if (state == ST_LOCKED) begin
        if (win_end) begin
          win_cnt  <= '0;
          win_errs <= '0;
        end else begin
          win_cnt  <= win_cnt + WIN_W'(1);
          win_errs <= win_errs + WE_W'(mismatch);
        end
      end
    end
  end

  // Error pulse and saturating bit/error counters; a clear beats a
  // simultaneous increment, but the pulse for that bit still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid && (state == ST_LOCKED)) begin
        if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
        if (mismatch) begin
          err_pulse <= 1'b1;
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
        end
      end
      if (clr_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed plus randomized stimulus for prbs_checker,
// compared every cycle against a queue-based behavioural model.
module tb_prbs_checker;

  localparam int          WIDTH      = 16;
  localparam logic [15:0] TAPS       = 16'hB400;
  localparam int          LOCK_COUNT = 32;
  localparam int          WINDOW     = 64;
  localparam int          LOSS_ERRS  = 8;
  localparam int          ERR_MAX    = 65535;
  localparam int          CNT_MAX    = 16777215;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [23:0] bit_count;

  int checks = 0;
  int errors = 0;

  prbs_checker #(
    .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
    .LOSS_ERRS(LOSS_ERRS), .ERR_W(16), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Reference generator state and valid bits sent since the last reset.
  logic [15:0] g;
  int          nbits;

  // Behavioural model: history as a queue of bits, newest at index 0.
  bit mh[$];
  int mfill, mmc, mwin, mwerr, merr, mbits;
  bit mlocked, mpulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_pred();
    bit p;
    p = 1'b0;
    for (int k = 0; k < WIDTH; k++) if (TAPS[k]) p = p ^ mh[k];
    return p;
  endfunction

  function automatic bit hist_nonzero();
    for (int k = 0; k < WIDTH; k++) if (mh[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mh.delete();
    repeat (WIDTH) mh.push_front(1'b0);
    mfill = 0; mmc = 0; mwin = 0; mwerr = 0; merr = 0; mbits = 0;
    mlocked = 1'b0; mpulse = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    bit p, mm, ok;
    p  = model_pred();
    mm = (p != b);
    if (!mlocked) begin
      ok = (mfill == WIDTH) && hist_nonzero() && !mm;
      mh.push_front(b);
      void'(mh.pop_back());
      if (mfill < WIDTH) mfill++;
      if (ok) begin
        mmc++;
        if (mmc == LOCK_COUNT) begin
          mlocked = 1'b1; mmc = 0; mwin = 0; mwerr = 0;
        end
      end else mmc = 0;
    end else begin
      mh.push_front(p);
      void'(mh.pop_back());
      if (mbits < CNT_MAX) mbits++;
      if (mm) begin
        mpulse = 1'b1;
        if (merr < ERR_MAX) merr++;
        mwerr++;
      end
      if (mwerr >= LOSS_ERRS) begin
        mlocked = 1'b0; mfill = 0; mmc = 0;
      end else begin
        mwin++;
        if (mwin == WINDOW) begin mwin = 0; mwerr = 0; end
      end
    end
  endtask

  task automatic gen_bit(output bit b);
    b = ^(g & TAPS);
    g = {g[14:0], b};
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input bit v, input bit flip, input bit c, input bit zero);
    bit b;
    b = 1'b0;
    if (v) begin
      if (!zero) begin
        gen_bit(b);
        b = b ^ flip;
      end
      nbits++;
    end
    in_valid = v; in_bit = b; clr_cnt = c;
    mpulse = 1'b0;
    if (v) model_bit(b);
    if (c) begin merr = 0; mbits = 0; end
    @(posedge clk); #1;
    chk("locked",    32'(locked),    32'(mlocked));
    chk("err_pulse", 32'(err_pulse), 32'(mpulse));
    chk("err_count", 32'(err_count), 32'(merr));
    chk("bit_count", 32'(bit_count), 32'(mbits));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    nbits = 0;
    chk("rst_locked",    32'(locked),    0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
  endtask

  initial begin
    int nb, ne, n, guard;
    g = 16'hACE1;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Acquisition: lock after 16 fill bits plus 32 matches.
    for (int i = 1; i <= 100; i++) begin
      step(1, 0, 0, 0);
      if (i == 47) chk("lock_bit47", 32'(locked), 0);
      if (i == 48) chk("lock_bit48", 32'(locked), 1);
    end
    chk("err_after_100",  32'(err_count), 0);
    chk("bits_after_100", 32'(bit_count), 52);

    // Single inverted bit at position 200.
    while (nbits < 199) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("pulse_200",  32'(err_pulse), 1);
    chk("err_200",    32'(err_count), 1);
    chk("locked_200", 32'(locked),    1);
    nb = int'(bit_count);
    step(1, 0, 0, 0);
    chk("pulse_off", 32'(err_pulse), 0);
    chk("bits_inc",  32'(bit_count), 32'(nb + 1));

    // in_valid gated low: everything frozen.
    nb = int'(bit_count); ne = int'(err_count);
    repeat (10) step(0, 0, 0, 0);
    chk("gate_bits", 32'(bit_count), 32'(nb));
    chk("gate_err",  32'(err_count), 32'(ne));
    chk("gate_lock", 32'(locked),    1);

    // Clear coinciding with a valid bit; counting resumes at 1.
    step(1, 0, 1, 0);
    chk("clr_err",    32'(err_count), 0);
    chk("clr_bits",   32'(bit_count), 0);
    step(1, 0, 0, 0);
    chk("clr_resume", 32'(bit_count), 1);

    // Eight errors inside one window, starting at a window boundary.
    guard = 0;
    while (mwin != 0 && guard < 200) begin step(1, 0, 0, 0); guard++; end
    chk("window_align", 32'(mwin), 0);
    for (int e = 0; e < 8; e++) begin
      if (e == 7) chk("locked_before_8th", 32'(locked), 1);
      step(1, 1, 0, 0);
      if (e < 7) begin step(1, 0, 0, 0); step(1, 0, 0, 0); end
    end
    chk("lost_after_8th", 32'(locked),    0);
    chk("err_burst",      32'(err_count), 8);

    // Re-lock on clean data.
    n = 0;
    while (!locked && n < 200) begin step(1, 0, 0, 0); n++; end
    chk("relock_bits", 32'(n), 48);

    // Randomized traffic: sparse errors, gaps and clears, then an error storm.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2, $urandom_range(0, 299) == 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 12, $urandom_range(0, 99) == 0, 0);
    guard = 0;
    while (!locked && guard < 400) begin step(1, 0, 0, 0); guard++; end
    repeat (20) step(1, 0, 0, 0);

    // Reset while locked.
    chk("pre_rst_lock", 32'(locked), 1);
    do_reset();

    // Stuck-at-zero input never locks.
    repeat (500) step(1, 0, 0, 1);
    chk("zero_locked", 32'(locked),    0);
    chk("zero_err",    32'(err_count), 0);
    chk("zero_bits",   32'(bit_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
